// File: rtl/logic_unit_stream.sv
// logic_unit_stream
//   WIDTH-bit bitwise logic unit with eight runtime-selectable operations.
//   It has two modes:
//     pairwise (mode=0): each accepted beat produces y = f(op, a, b).
//     reduce   (mode=1): b is folded into an accumulator across a burst.
//   A reduce burst emits one result on in_last, or when MAX_LEN beats have
//   been folded (forced emit).
//
// Handshake (both sides):
//   A beat is accepted when in_valid && in_ready.
//   A result is consumed when out_valid && out_ready.
//   in_ready = !out_valid || out_ready. Because of this there is a
//   combinational path from out_ready to in_ready.
//   y, y_par and out_valid hold while out_valid && !out_ready.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   in_valid / in_ready   input beat handshake
//   a, b, op, mode        operands, operation select, pairwise/reduce mode
//   in_last               reduce mode: final beat of the burst
//   out_valid / out_ready result handshake
//   y                     registered result
//   y_par                 even parity of y (XOR-reduce). It is built only
//                         when LOGIC_UNIT_PARITY_EN is defined; otherwise
//                         it is tied to 0.
//
// Op encoding (X = a in pairwise, X = accumulator in reduce; Y = b):
//   0 X|Y  1 X&Y  2 X^Y  3 ~(X|Y)  4 ~(X&Y)  5 ~(X^Y)  6 X&~Y  7 X
module logic_unit_stream #(
  parameter int WIDTH   = 8,
  parameter int MAX_LEN = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             mode,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             y_par
);

  localparam int CW = $clog2(MAX_LEN + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_LEN);

  typedef enum logic {IDLE = 1'b0, ACC = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [2:0]       op_q, op_d;
  logic             mode_q, mode_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             vld_q, vld_d;

  logic             fire;
  logic             consume;
  logic [WIDTH-1:0] fold_x;
  logic [WIDTH-1:0] fold_res;
  logic [CW-1:0]    cnt_inc;

  function automatic logic [WIDTH-1:0] f_op(input logic [2:0]       o,
                                            input logic [WIDTH-1:0] x,
                                            input logic [WIDTH-1:0] yv);
    logic [WIDTH-1:0] r;
    case (o)
      3'd0:    r = x | yv;
      3'd1:    r = x & yv;
      3'd2:    r = x ^ yv;
      3'd3:    r = ~(x | yv);
      3'd4:    r = ~(x & yv);
      3'd5:    r = ~(x ^ yv);
      3'd6:    r = x & ~yv;
      default: r = x;
    endcase
    return r;
  endfunction

  assign in_ready = !vld_q || out_ready;
  assign fire     = in_valid && in_ready;
  assign consume  = vld_q && out_ready;

  // In ACC the latched mode is always reduce, so X is the accumulator.
  // The live op, mode and a are ignored for the rest of the burst.
  assign fold_x   = mode_q ? acc_q : a;
  assign fold_res = f_op(op_q, fold_x, b);
  assign cnt_inc  = cnt_q + CW'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    op_d    = op_q;
    mode_d  = mode_q;
    y_d     = y_q;
    // A consumed result drops out_valid. A result produced in the same
    // cycle sets it again below.
    vld_d   = consume ? 1'b0 : vld_q;

    if (fire) begin
      case (state_q)
        IDLE: begin
          if (!mode) begin
            y_d   = f_op(op, a, b);
            vld_d = 1'b1;
          end else begin
            acc_d  = b;
            op_d   = op;
            mode_d = 1'b1;
            cnt_d  = CW'(1);
            if (in_last) begin
              y_d   = b;
              vld_d = 1'b1;
            end else begin
              state_d = ACC;
            end
          end
        end
        ACC: begin
          acc_d = fold_res;
          if (in_last || cnt_inc == MAX_CNT) begin
            y_d     = fold_res;
            vld_d   = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      op_q    <= '0;
      mode_q  <= 1'b0;
      y_q     <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      op_q    <= op_d;
      mode_q  <= mode_d;
      y_q     <= y_d;
      vld_q   <= vld_d;
    end
  end

  assign y         = y_q;
  assign out_valid = vld_q;

`ifdef LOGIC_UNIT_PARITY_EN
  // Parity tracks y_d, so it follows the same update and hold rules as y.
  logic par_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_q <= 1'b0;
    else        par_q <= ^y_d;
  end
  assign y_par = par_q;
`else
  assign y_par = 1'b0;
`endif

endmodule

// File: tb/tb_logic_unit_stream.sv
module tb_logic_unit_stream;

  localparam int WIDTH   = 8;
  localparam int MAX_LEN = 4;

  // ---------------- clock / reset ----------------
  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             mode;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             y_par;

  int tests_run = 0;
  int tests_failed = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic_unit_stream #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .mode      (mode),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .y_par     (y_par)
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic exp_par(input logic [WIDTH-1:0] v);
`ifdef LOGIC_UNIT_PARITY_EN
    return ^v;
`else
    return 1'b0;
`endif
  endfunction

  // The check for an expected result also checks y and y_par.
  task automatic check_out(input string tag, input logic ev, input logic [WIDTH-1:0] ey);
    check({tag, "_valid"}, 64'(out_valid), 64'(ev));
    if (ev) begin
      check({tag, "_y"},   64'(y),     64'(ey));
      check({tag, "_par"}, 64'(y_par), 64'(exp_par(ey)));
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change on the falling edge. DUT outputs are sampled on the
  // falling edge as well.
  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                       input logic [2:0] top, input logic tm, input logic tl);
    in_valid = 1'b1;
    a        = ta;
    b        = tb_v;
    op       = top;
    mode     = tm;
    in_last  = tl;
  endtask

  task automatic idle_in;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic [WIDTH-1:0] pw_exp [8];
  logic [WIDTH-1:0] and_b  [5];

  initial begin
    pw_exp = '{8'hAF, 8'h00, 8'hAF, 8'h50, 8'hFF, 8'h50, 8'hA0, 8'hA0};
    and_b  = '{8'hFF, 8'hF0, 8'h3C, 8'h0C, 8'h04};

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; op = '0;
    mode = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_valid", 64'(out_valid), 64'd0);
    check("reset_y",     64'(y),         64'd0);
    check("reset_par",   64'(y_par),     64'd0);
    check("reset_ready", 64'(in_ready),  64'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Pairwise: all eight ops back to back, one beat per cycle.
    for (int i = 0; i < 8; i++) begin
      drive(8'hA0, 8'h0F, 3'(i), 1'b0, (i == 3));  // in_last is ignored here
      tick();
      check_out($sformatf("pw_op%0d", i), 1'b1, pw_exp[i]);
    end
    idle_in();
    tick();
    check_out("pw_drain", 1'b0, 8'h00);

    // Backpressure: the result must hold and in_ready must stay low.
    drive(8'hFF, 8'h0F, 3'd2, 1'b0, 1'b0);
    tick();
    out_ready = 1'b0;
    drive(8'h12, 8'h34, 3'd0, 1'b0, 1'b0);  // offered, must not be taken
    #1;
    check("bp_ready_low", 64'(in_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out($sformatf("bp_hold%0d", i), 1'b1, 8'hF0);
      check($sformatf("bp_ready%0d", i), 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_ready_rel", 64'(in_ready), 64'd1);
    tick();
    check_out("bp_replace", 1'b1, 8'h36);
    idle_in();
    tick();
    check_out("bp_drain", 1'b0, 8'h00);

    // Reduce XOR 01^02^04^08. The live op changes mid-burst and must be ignored.
    drive(8'h00, 8'h01, 3'd2, 1'b1, 1'b0); tick(); check_out("rx_b1", 1'b0, 8'h00);
    check("rx_acc_ready", 64'(in_ready), 64'd1);
    drive(8'hFF, 8'h02, 3'd0, 1'b0, 1'b0); tick(); check_out("rx_b2", 1'b0, 8'h00);
    drive(8'hFF, 8'h04, 3'd0, 1'b1, 1'b0); tick(); check_out("rx_b3", 1'b0, 8'h00);
    drive(8'hFF, 8'h08, 3'd0, 1'b1, 1'b1); tick(); check_out("rx_res", 1'b1, 8'h0F);
    idle_in();
    tick();
    check_out("rx_drain", 1'b0, 8'h00);

    // Reduce OR that ends on in_last before MAX_LEN, with an idle gap in ACC.
    drive(8'h00, 8'h10, 3'd0, 1'b1, 1'b0); tick(); check_out("ro_b1", 1'b0, 8'h00);
    idle_in();
    repeat (3) tick();
    check_out("ro_gap", 1'b0, 8'h00);
    drive(8'h00, 8'h20, 3'd1, 1'b1, 1'b0); tick(); check_out("ro_b2", 1'b0, 8'h00);
    drive(8'h00, 8'h40, 3'd1, 1'b1, 1'b1); tick(); check_out("ro_res", 1'b1, 8'h70);
    idle_in();
    tick();

    // Forced emit at MAX_LEN=4: AND of FF,F0,3C,0C is 00. A 5th beat starts a new burst.
    for (int i = 0; i < 4; i++) begin
      drive(8'h00, and_b[i], 3'd1, 1'b1, 1'b0);
      tick();
      check_out($sformatf("fe_b%0d", i + 1), (i == 3), 8'h00);
    end
    drive(8'h00, and_b[4], 3'd1, 1'b1, 1'b1);
    tick();
    check_out("fe_new", 1'b1, 8'h04);
    idle_in();
    tick();

    // Reset mid-burst: y (still 04) and out_valid clear immediately.
    drive(8'h00, 8'h0F, 3'd0, 1'b1, 1'b0); tick();
    drive(8'h00, 8'hF0, 3'd0, 1'b1, 1'b0); tick();
    idle_in();
    #2 rst_n = 1'b0;
    #1;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_y",     64'(y),         64'd0);
    check("rst_par",   64'(y_par),     64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drive(8'h00, 8'h11, 3'd0, 1'b1, 1'b1);
    tick();
    check_out("rst_single", 1'b1, 8'h11);
    idle_in();
    tick();

    // Parity, using pass-through of a.
    drive(8'h07, 8'h00, 3'd7, 1'b0, 1'b0); tick(); check_out("par_07", 1'b1, 8'h07);
    drive(8'h03, 8'h00, 3'd7, 1'b0, 1'b0); tick(); check_out("par_03", 1'b1, 8'h03);
    idle_in();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
